// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 slave backed by word SRAM, FIXED/INCR/WRAP bursts; optional stalls via AXI_SLAVE_RAND_DELAY_EN
module axi_sram_slave #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);
  typedef enum logic {R_IDLE, R_BURST} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  rstate_t r_rstate, w_rstate_nx;
  wstate_t r_wstate, w_wstate_nx;
  logic [31:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic        r_live, r_rvalid, r_bvalid, r_werr;
  logic [31:0] r_raddr, r_waddr, r_rdata, w_rnext, w_wnext;
  logic [7:0]  r_rlen, r_wlen, r_rbeat, r_wbeat;
  logic [2:0]  r_rsize, r_wsize;
  logic [1:0]  r_rburst, r_wburst, r_bresp;
  logic [3:0]  r_rid, r_bid;
  logic        w_ar_go, w_aw_go, w_w_go, w_rv_go, w_bv_go;
  logic        w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs, w_rfinal, w_wfinal, w_beat_err;
  logic        w_unused;

  function automatic logic [31:0] f_next(input logic [31:0] a, input logic [7:0] len,
                                         input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] inc, mask;
    inc  = 32'd1 << size;
    mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
    f_next = burst == 2'b00 ? a : burst == 2'b10 ? (a & ~mask) | ((a + inc) & mask) : a + inc;
  endfunction

`ifdef AXI_SLAVE_RAND_DELAY_EN
  logic [15:0] r_lfsr;
  // free-running stall pattern generator
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) r_lfsr <= 16'hACE1;
    else r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  assign {w_bv_go, w_rv_go, w_w_go, w_aw_go, w_ar_go} = r_lfsr[4:0];
`else
  assign {w_bv_go, w_rv_go, w_w_go, w_aw_go, w_ar_go} = 5'b11111;
`endif

  assign w_unused   = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};
  assign arready    = r_live & (r_rstate == R_IDLE) & w_ar_go;
  assign awready    = r_live & (r_wstate == W_IDLE) & w_aw_go;
  assign wready     = (r_wstate == W_DATA) & w_w_go;
  assign rvalid     = r_rvalid;
  assign rdata      = r_rdata;
  assign rid        = r_rid;
  assign rresp      = 2'b00;
  assign rlast      = r_rvalid & w_rfinal;
  assign bvalid     = r_bvalid;
  assign bid        = r_bid;
  assign bresp      = r_bresp;
  assign w_ar_hs    = arvalid & arready;
  assign w_r_hs     = r_rvalid & rready;
  assign w_aw_hs    = awvalid & awready;
  assign w_w_hs     = wvalid & wready;
  assign w_b_hs     = r_bvalid & bready;
  assign w_rfinal   = r_rbeat == r_rlen;
  assign w_wfinal   = r_wbeat == r_wlen;
  assign w_beat_err = w_wfinal ? ~wlast : wlast;
  assign w_rnext    = f_next(r_raddr, r_rlen, r_rsize, r_rburst);
  assign w_wnext    = f_next(r_waddr, r_wlen, r_wsize, r_wburst);

  // next-state logic for both engines
  always_comb begin
    w_rstate_nx = r_rstate == R_IDLE ? (w_ar_hs ? R_BURST : R_IDLE)
                                     : (w_r_hs && w_rfinal ? R_IDLE : R_BURST);
    w_wstate_nx = r_wstate == W_IDLE ? (w_aw_hs ? W_DATA : W_IDLE)
                : r_wstate == W_DATA ? (w_w_hs && w_wfinal ? W_RESP : W_DATA)
                                     : (w_b_hs ? W_IDLE : W_RESP);
  end

  // state registers; r_live holds address readies low until the first edge after reset
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      r_rstate <= R_IDLE;
      r_wstate <= W_IDLE;
      r_live   <= 1'b0;
    end else begin
      r_rstate <= w_rstate_nx;
      r_wstate <= w_wstate_nx;
      r_live   <= 1'b1;
    end

  // read engine: capture burst, prefetch each beat into rdata, hold while stalled
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      r_rid    <= '0;
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rsize  <= '0;
      r_rburst <= '0;
      r_rbeat  <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else if (w_ar_hs) begin
      r_rid    <= arid;
      r_raddr  <= araddr;
      r_rlen   <= arlen;
      r_rsize  <= arsize;
      r_rburst <= arburst;
      r_rbeat  <= '0;
      r_rdata  <= r_mem[araddr[ADDR_WIDTH+1:2]];
      r_rvalid <= w_rv_go;
    end else if (w_r_hs) begin
      r_raddr  <= w_rnext;
      r_rbeat  <= r_rbeat + 8'd1;
      r_rdata  <= r_mem[w_rnext[ADDR_WIDTH+1:2]];
      r_rvalid <= ~w_rfinal & w_rv_go;
    end else if (r_rstate == R_BURST && !r_rvalid) begin
      r_rvalid <= w_rv_go;
    end

  // write engine: track beats, accumulate wlast placement errors, raise response
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      r_bid    <= '0;
      r_waddr  <= '0;
      r_wlen   <= '0;
      r_wsize  <= '0;
      r_wburst <= '0;
      r_wbeat  <= '0;
      r_werr   <= 1'b0;
      r_bresp  <= '0;
      r_bvalid <= 1'b0;
    end else if (w_aw_hs) begin
      r_bid    <= awid;
      r_waddr  <= awaddr;
      r_wlen   <= awlen;
      r_wsize  <= awsize;
      r_wburst <= awburst;
      r_wbeat  <= '0;
      r_werr   <= 1'b0;
    end else if (w_w_hs) begin
      r_waddr  <= w_wnext;
      r_wbeat  <= r_wbeat + 8'd1;
      r_werr   <= r_werr | w_beat_err;
      r_bresp  <= w_wfinal ? ((r_werr | w_beat_err) ? 2'b10 : 2'b00) : r_bresp;
      r_bvalid <= w_wfinal & w_bv_go;
    end else if (w_b_hs) begin
      r_bvalid <= 1'b0;
    end else if (r_wstate == W_RESP && !r_bvalid) begin
      r_bvalid <= w_bv_go;
    end

  // byte-enabled SRAM write, contents survive reset
  always_ff @(posedge aclk)
    if (w_w_hs)
      for (int i = 0; i < 4; i++)
        if (wstrb[i]) r_mem[r_waddr[ADDR_WIDTH+1:2]][8*i +: 8] <= wdata[8*i +: 8];
endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI3 slave memory model that sits directly downstream of `core_top`, consuming its AXI master port (AR/R/AW/W/B) in simulation and board-less bring-up. It is backed by an internal word-addressed SRAM and supports FIXED, INCR and WRAP bursts with independent read and write engines. It is the default memory behind the core for ICache/DCache refill, writeback and uncached traffic, so its burst and back-pressure behaviour is normative for bridge verification.

## Interface

- `ADDR_WIDTH`, 16: word-index bits; capacity is 2^ADDR_WIDTH 32-bit words. Address bits above `ADDR_WIDTH+1` are ignored (aliasing).
- `aclk` in 1: single clock; all logic rises on `aclk`.
- `aresetn` in 1: reset is asynchronous and active-low.
- `arid` in 4, `araddr` in 32, `arlen` in 8, `arsize` in 3, `arburst` in 2, `arlock` in 2, `arcache` in 4, `arprot` in 3, `arvalid` in 1: read address channel (`arlock`, `arcache`, `arprot` ignored).
- `arready` out 1: read address accept.
- `rid` out 4, `rdata` out 32, `rresp` out 2, `rlast` out 1, `rvalid` out 1; `rready` in 1: read data channel.
- `awid` in 4, `awaddr` in 32, `awlen` in 8, `awsize` in 3, `awburst` in 2, `awlock` in 2, `awcache` in 4, `awprot` in 3, `awvalid` in 1; `awready` out 1: write address channel.
- `wid` in 4 (ignored), `wdata` in 32, `wstrb` in 4, `wlast` in 1, `wvalid` in 1; `wready` out 1: write data channel.
- `bid` out 4, `bresp` out 2, `bvalid` out 1; `bready` in 1: write response channel.

## Operation

- Read FSM: `R_IDLE` -> (`arvalid & arready`) -> `R_BURST` -> (`rvalid & rready & rlast`) -> `R_IDLE`. `arready` = 1 only in `R_IDLE`. One outstanding read.
- On AR handshake, capture id, addr, len, size, burst; beat counter cleared. `rdata` register loaded from mem[addr word]; `rvalid` asserts.
- Each R handshake advances: FIXED holds addr; INCR adds `1<<size`; WRAP adds `1<<size` then wraps within an aligned window of `(len+1)<<size` bytes. Burst code 2'b11 treated as INCR. Data is always the full aligned 32-bit word.
- `rlast` = 1 when beat counter == captured len. `rresp` always 2'b00; `rid` = captured id.
- Write FSM: `W_IDLE` -> AW handshake -> `W_DATA` -> final beat -> `W_RESP` -> (`bvalid & bready`) -> `W_IDLE`. `awready` = 1 only in `W_IDLE`; `wready` = 1 only in `W_DATA`.
- Each W handshake writes bytes of `wdata` enabled by `wstrb` to current address, then advances as for reads.
- Final beat is decided by beat counter == len, not `wlast`. `bresp` = 2'b10 (SLVERR) if `wlast` was 0 on the final beat or 1 on any earlier beat; else 2'b00. `bid` = captured awid.
- Read and write engines run concurrently. Same-word collision: a write committed on edge C is visible to read beats whose `rdata` is loaded on edge C+1 or later; a load on edge C returns old data.
- Memory contents are not reset.

## Timing

- Reset (async, `aresetn` low): `arready`, `awready`, `wready`, `rvalid`, `bvalid`, `rlast` = 0; `rid`, `bid`, `rdata`, `rresp`, `bresp` = 0; both FSMs to IDLE. Applies immediately, including mid-burst; the partial burst is abandoned.
- First edge after reset release: `arready` = `awready` = 1.
- Read latency: AR handshake on edge N -> first beat `rvalid` at N (registered, visible after edge N), i.e. one cycle after the address was presented. Subsequent beats back-to-back when `rready` = 1.
- Write: AW handshake edge N -> `wready` after N; last W handshake edge M -> `bvalid` after M.
- `rvalid`/`bvalid`, once asserted, hold with stable payload until handshake. `rready` low keeps `rdata`, `rid`, `rlast` unchanged.
- After `rlast` or B handshake, `arready`/`awready` return after the same edge (one idle cycle minimum between bursts).

## Configuration

- `AXI_SLAVE_RAND_DELAY_EN`: when defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1, advancing every cycle) gates `arready`, `awready`, `wready` and the *assertion* of `rvalid`/`bvalid` with LFSR bits [0],[1],[2],[3],[4] respectively; an already-asserted valid is never dropped. When undefined, no stalls: behaviour exactly as in Timing.

## Test plan

- Single read: preload word 0x100 = 0xDEADBEEF; AR addr 0x100, len 0, id 3, INCR -> one beat `rdata` 0xDEADBEEF, `rid` 3, `rlast` 1, `rresp` 0.
- INCR write/readback: AW 0x200 len 3 id 5, W data 1,2,3,4 `wstrb` 0xF, `wlast` on beat 4 -> `bid` 5 `bresp` 0; read 0x200 len 3 returns 1,2,3,4, `rlast` only on 4th.
- WRAP read: words 0x200..0x20C = A,B,C,D; AR 0x208 len 3 size 2 WRAP -> C,D,A,B.
- Partial strobe and wlast error: word 0x300 = 0x11223344, write 0xAABBCCDD `wstrb` 0x5 -> 0x11BB33DD; len 1 write with `wlast` 0 on beat 2 -> `bresp` 2'b10.
- Back-pressure: `rready` low 3 cycles during len 3 read -> `rdata`/`rid`/`rlast` stable, no beat lost or duplicated.
- Reset mid-burst: drop `aresetn` during beat 2 of len 7 read -> `rvalid` 0 at once; after release `arready` 1 next edge; prior memory contents intact.
